lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store controller for the MEM stage of the pipelined CPU. It is the initiator side of the data-memory port: it accepts one load or store request at a time from the pipeline and drives the word-addressed data memory (address, write data, write strobe). It reads returned data back, and adds byte/halfword access through read-modify-write. It returns a single-cycle response carrying sign- or zero-extended load data, or a misalignment error.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data width; fixed at 32, since the lane logic assumes 4 bytes.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request; equals (state == IDLE).
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_signed`  in  1: load sign-extends when 1, zero-extends when 0.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_err`  out  1: misaligned or unsupported access; valid with `resp_valid`.
- `resp_rdata`  out  32: load result; 0 for stores and errors.
- `mem_address`  out  ADDR_W: word-aligned address {req_addr[ADDR_W-1:2], 2'b00}.
- `mem_data_in`  out  32: write data to memory.
- `mem_write`  out  1: write strobe; memory commits on the rising edge while high.
- `mem_data_out`  in  32: memory read data; valid by the rising edge following the cycle in which `mem_address` is driven.

## Operation
- Accept: a request is accepted on a rising edge with `req_valid && req_ready && !reset`. The edge registers addr, size, signed, write, and wdata.
- Alignment check at accept:
  - half requires addr[0] = 0.
  - word requires addr[1:0] = 0.
  - size 3 is always an error.
  - An error skips memory entirely: next cycle `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0, state stays IDLE.
- State machine states: IDLE, READ, WRITE.
  - IDLE → WRITE: word store.
  - IDLE → READ: load, or byte/half store.
  - READ → IDLE: load; capture and extract data.
  - READ → WRITE: sub-word store; capture the old word and merge.
  - WRITE → IDLE: always.
- Byte lanes are little-endian: addr[1:0] = 0 selects bits 7:0; a half at addr[1] = 1 selects bits 31:16.
- Load extract: selected byte/half is shifted to bit 0, then extended according to the registered signed flag.
- Store merge: only the selected lanes are replaced with the low bits of wdata; other lanes keep the captured word.
- `mem_write` is high only in WRITE. `mem_address` holds the last accepted word address while idle.

## Timing
- Reset values:
  - state = IDLE, so `req_ready` reads 1; requests are ignored while reset is high.
  - `resp_valid`, `resp_err`, `mem_write` = 0.
  - `resp_rdata`, `mem_address`, `mem_data_in` = 0.
- Latency, from accept edge A to the `resp_valid` cycle:
  - error: 1 cycle.
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
- Back-to-back: the `resp_valid` cycle is spent in IDLE, so a new request may be accepted in the same cycle `resp_valid` is high. Sustained throughput is one load per 2 cycles.
- A load issued right after a store to the same word returns the new data, because the write has committed before READ.
- Reset mid-operation aborts immediately. `mem_write` drops asynchronously, so a store whose WRITE cycle is cut by reset before its edge is not committed, and no response is issued.

## Configuration
- `LSU_SUBWORD_EN` defined: byte and half accesses are supported as described above.
- `LSU_SUBWORD_EN` undefined:
  - size 0 or 1 is treated as an error (1-cycle `resp_err`).
  - No read-modify-write path exists; a store never enters READ.
  - Lane extract/merge logic is removed.

## Structure
- Package `lsu_pkg`:
  - size encodings: SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - state enum.
  - function checking alignment.
- Sub-module `lsu_lane_merge`, purely combinational:
  - inputs: old word, wdata, addr[1:0], size, signed.
  - outputs: the merged store word and the extended load word.
  - instantiated only under `LSU_SUBWORD_EN`.

## Test plan
1. Word store then load: store 0xDEADBEEF at 0x10, then load word from 0x10.
   - Expect: `mem_write` high for exactly one cycle, address 0x10.
   - Expect: load response 0xDEADBEEF, 2 cycles after accept.
2. Signed/unsigned byte load: memory word at 0x20 = 0x80FF7F01.
   - lb 0x22 → 0xFFFFFFFF.
   - lbu 0x23 → 0x00000080.
   - lb 0x21 → 0x0000007F.
3. Sub-word store merge: word 0x11223344 at 0x30.
   - sh 0xAABB at 0x32 → memory 0xAABB3344, response 3 cycles after accept.
   - sb 0xCC at 0x31 → memory 0xAABBCC44.
4. Misalignment:
   - lw at 0x05 → `resp_err` = 1, `resp_rdata` = 0, 1-cycle latency, `mem_write` never high.
   - lh at 0x07 → same response.
   - size 3 → same response.
5. Reset mid-store: sb at 0x40 over 0x00000000; assert reset during the WRITE cycle before the edge.
   - Expect: memory stays 0.
   - Expect: all outputs return to reset values; no `resp_valid`.
6. Back-to-back: hold `req_valid` with alternating lw/sw to 0x50.
   - Expect: a new accept in every `resp_valid` cycle; no request lost or duplicated.
   - With `LSU_SUBWORD_EN` undefined, lb → 1-cycle error.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_pkg                                                         |
// | Purpose  : Shared encodings and helpers for the load/store controller:     |
// |            access-size codes, controller state enum and the alignment      |
// |            check applied when a request is accepted.                       |
// | Ports    : none (package)                                                  |
// | Config   : LSU_SUBWORD_EN is resolved by the caller, which passes it to    |
// |            lsu_misaligned() as the subword_en argument.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } lsu_state_t;

   // Returns 1 when the access cannot be performed: reserved size, a
   // misaligned half/word, or any sub-word access when sub-word support
   // is not built in.
   function automatic logic lsu_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo,
                                           input logic       subword_en);
      logic err;
      err = 1'b0;
      case (size)
         SZ_BYTE: err = !subword_en;
         SZ_HALF: err = !subword_en || addr_lo[0];
         SZ_WORD: err = (addr_lo != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_lane_merge                                                  |
// | Purpose  : Combinational little-endian lane logic. Builds the store word   |
// |            for a byte/half read-modify-write and the sign/zero-extended    |
// |            load result from a memory word.                                 |
// | Ports    : old_word_i  32  word read from memory                           |
// |            wdata_i     32  right-aligned store data                        |
// |            addr_lo_i    2  byte offset inside the word                     |
// |            size_i       2  access size (lsu_pkg SZ_*)                      |
// |            signed_i     1  sign-extend loads when 1                        |
// |            merged_o    32  old word with selected lanes replaced           |
// |            load_ext_o  32  selected lanes shifted to bit 0 and extended    |
// | Config   : only instantiated when LSU_SUBWORD_EN is defined.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module lsu_lane_merge
   import lsu_pkg::*;
(
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] merged_o,
   output logic [31:0] load_ext_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [4:0]  byte_shift;

   assign byte_shift = {addr_lo_i, 3'b000};

   always_comb begin
      merged_o   = old_word_i;
      load_ext_o = old_word_i;
      byte_sel   = old_word_i[byte_shift +: 8];
      half_sel   = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
      case (size_i)
         SZ_BYTE: begin
            merged_o[byte_shift +: 8] = wdata_i[7:0];
            load_ext_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            if (addr_lo_i[1]) begin
               merged_o[31:16] = wdata_i[15:0];
            end else begin
               merged_o[15:0] = wdata_i[15:0];
            end
            load_ext_o = {{16{signed_i & half_sel[15]}}, half_sel};
         end
         default: begin
            // Word accesses pass straight through.
            merged_o   = wdata_i;
            load_ext_o = old_word_i;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_ctrl                                                        |
// | Purpose  : MEM-stage load/store controller. Accepts one request at a time, |
// |            drives a word-addressed data memory and returns a one-cycle     |
// |            response with extended load data or an error flag.             |
// | Ports    : clock, reset        clock / async active-high reset             |
// |            req_valid/req_ready request handshake (ready == IDLE)           |
// |            req_write/size/signed/addr/wdata   request fields               |
// |            resp_valid/err/rdata               one-cycle response           |
// |            mem_address/data_in/write          memory command              |
// |            mem_data_out                       memory read data            |
// | Config   : LSU_SUBWORD_EN  enables byte/half access (read-modify-write     |
// |            for stores); undefined makes byte/half requests errors.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_data_out
);

`ifdef LSU_SUBWORD_EN
   localparam logic SUBWORD_EN = 1'b1;
`else
   localparam logic SUBWORD_EN = 1'b0;
`endif

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

   logic accept;
   logic misaligned;

   assign accept     = req_valid && (state_q == ST_IDLE);
   assign misaligned = lsu_misaligned(req_size, req_addr[1:0], SUBWORD_EN);

`ifdef LSU_SUBWORD_EN
   // Request fields needed after accept for extract / merge.
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [31:0]       merged_word;
   logic [31:0]       load_word;

   lsu_lane_merge u_lane_merge (
      .old_word_i (mem_data_out),
      .wdata_i    (wdata_q),
      .addr_lo_i  (addr_lo_q),
      .size_i     (size_q),
      .signed_i   (signed_q),
      .merged_o   (merged_word),
      .load_ext_o (load_word)
   );
`else
   logic unused_signed;
   assign unused_signed = req_signed;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         mem_address_q <= '0;
         mem_data_in_q <= '0;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_rdata_q  <= '0;
`ifdef LSU_SUBWORD_EN
         write_q       <= 1'b0;
         size_q        <= SZ_WORD;
         signed_q      <= 1'b0;
         addr_lo_q     <= 2'b00;
         wdata_q       <= '0;
`endif
      end else begin
         state_q       <= state_d;
         mem_address_q <= mem_address_d;
         mem_data_in_q <= mem_data_in_d;
         resp_valid_q  <= resp_valid_d;
         resp_err_q    <= resp_err_d;
         resp_rdata_q  <= resp_rdata_d;
`ifdef LSU_SUBWORD_EN
         write_q       <= write_d;
         size_q        <= size_d;
         signed_q      <= signed_d;
         addr_lo_q     <= addr_lo_d;
         wdata_q       <= wdata_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_address_d = mem_address_q;
      mem_data_in_d = mem_data_in_q;
      resp_valid_d  = 1'b0;
      resp_err_d    = 1'b0;
      resp_rdata_d  = '0;
`ifdef LSU_SUBWORD_EN
      write_d       = write_q;
      size_d        = size_q;
      signed_d      = signed_q;
      addr_lo_d     = addr_lo_q;
      wdata_d       = wdata_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mem_address_d = {req_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_SUBWORD_EN
               write_d   = req_write;
               size_d    = req_size;
               signed_d  = req_signed;
               addr_lo_d = req_addr[1:0];
               wdata_d   = req_wdata;
`endif
               if (misaligned) begin
                  // Error response next cycle; memory is never touched.
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_write) begin
                  mem_data_in_d = req_wdata;
`ifdef LSU_SUBWORD_EN
                  // Sub-word stores fetch the old word first.
                  state_d = (req_size == SZ_WORD) ? ST_WRITE : ST_READ;
`else
                  state_d = ST_WRITE;
`endif
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
`ifdef LSU_SUBWORD_EN
            if (write_q) begin
               mem_data_in_d = merged_word;
               state_d       = ST_WRITE;
            end else begin
               resp_valid_d = 1'b1;
               resp_rdata_d = load_word;
               state_d      = ST_IDLE;
            end
`else
            resp_valid_d = 1'b1;
            resp_rdata_d = mem_data_out;
            state_d      = ST_IDLE;
`endif
         end
         ST_WRITE: begin
            resp_valid_d = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Decoded straight from the state register so reset removes the write
   // strobe asynchronously.
   assign mem_write   = (state_q == ST_WRITE);
   assign req_ready   = (state_q == ST_IDLE);
   assign mem_address = mem_address_q;
   assign mem_data_in = mem_data_in_q;
   assign resp_valid  = resp_valid_q;
   assign resp_err    = resp_err_q;
   assign resp_rdata  = resp_rdata_q;

endmodule
`default_nettype wire
